// File: rtl/branch_update_queue.sv
// In-order queue of predicted branches awaiting resolution. It emits a registered
// training pulse for the history/pattern tables and a flush pulse on a misprediction.
module branch_update_queue #(
   parameter int unsigned IWIDTH = 6,
   parameter int unsigned HWIDTH = 6,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       push,
   input  logic [IWIDTH-1:0]          push_index,
   input  logic [HWIDTH-1:0]          push_hist,
   input  logic                       push_taken,
   input  logic                       resolve,
   input  logic                       resolve_taken,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       do_update,
   output logic                       last_taken,
   output logic [IWIDTH-1:0]          upd_index,
   output logic [HWIDTH-1:0]          upd_hist,
   output logic                       flush,
   output logic [15:0]                mispredicts,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [IWIDTH-1:0] index;
      logic [HWIDTH-1:0] hist;
      logic              taken;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          head_entry;
   entry_t          push_entry;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   occ;

   logic            accept_res;
   logic            mispredict;
   logic            accept_push;
   logic            drop_push;
   logic            underflow_evt;

   // Occupancy flags are combinational views of the occupancy register.
   assign full  = (occ == CW'(DEPTH));
   assign empty = (occ == '0);
   assign count = occ;

   assign head_entry = mem[head];
   assign push_entry = '{index: push_index, hist: push_hist, taken: push_taken};

   // A resolve pops the head only when something is queued. A full queue
   // accepts a push in the same cycle as the pop. A misprediction also
   // cancels any same-cycle push.
   always_comb begin
      accept_res    = en & resolve & ~empty;
      mispredict    = accept_res & (resolve_taken != head_entry.taken);
      accept_push   = en & push & (~full | accept_res) & ~mispredict;
      drop_push     = en & push & full & ~accept_res;
      underflow_evt = en & resolve & empty;
   end

   // Pointer and occupancy state; a misprediction empties the queue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else if (mispredict) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (accept_res)  head <= head + PW'(1);
         if (accept_push) tail <= tail + PW'(1);
         occ <= occ + CW'(accept_push) - CW'(accept_res);
      end
   end

   // Entry storage has no reset; entries are only read after being written.
   always_ff @(posedge clk) begin
      if (accept_push) mem[tail] <= push_entry;
   end

   // Registered training, flush and status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         do_update   <= 1'b0;
         last_taken  <= 1'b0;
         upd_index   <= '0;
         upd_hist    <= '0;
         flush       <= 1'b0;
         mispredicts <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else if (en) begin
         do_update <= accept_res;
         flush     <= mispredict;
         if (accept_res) begin
            last_taken <= resolve_taken;
            upd_index  <= head_entry.index;
            upd_hist   <= head_entry.hist;
         end
         if (mispredict && (mispredicts != 16'hFFFF)) mispredicts <= mispredicts + 16'd1;
         if (drop_push)     overflow  <= 1'b1;
         if (underflow_evt) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_update_queue.sv
// Bench for branch_update_queue: directed scenarios followed by random traffic,
// each cycle compared against a queue-based reference model.
module tb_branch_update_queue;

   localparam int unsigned IWIDTH = 6;
   localparam int unsigned HWIDTH = 6;
   localparam int unsigned DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              en = 1'b0;
   logic              push = 1'b0;
   logic [IWIDTH-1:0] push_index = '0;
   logic [HWIDTH-1:0] push_hist = '0;
   logic              push_taken = 1'b0;
   logic              resolve = 1'b0;
   logic              resolve_taken = 1'b0;
   logic              full, empty;
   logic [$clog2(DEPTH):0] count;
   logic              do_update, last_taken, flush, overflow, underflow;
   logic [IWIDTH-1:0] upd_index;
   logic [HWIDTH-1:0] upd_hist;
   logic [15:0]       mispredicts;

   branch_update_queue #(.IWIDTH(IWIDTH), .HWIDTH(HWIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .en(en), .push(push), .push_index(push_index),
      .push_hist(push_hist), .push_taken(push_taken), .resolve(resolve),
      .resolve_taken(resolve_taken), .full(full), .empty(empty), .count(count),
      .do_update(do_update), .last_taken(last_taken), .upd_index(upd_index),
      .upd_hist(upd_hist), .flush(flush), .mispredicts(mispredicts),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IWIDTH-1:0] idx;
      logic [HWIDTH-1:0] hist;
      logic              tk;
   } ent_t;

   ent_t              mq[$];
   logic              m_do, m_last, m_flush, m_over, m_under;
   logic [IWIDTH-1:0] m_idx;
   logic [HWIDTH-1:0] m_hist;
   logic [15:0]       m_misp;
   int                total = 0;
   int                bad = 0;
   string             cur_tag = "reset";

   task automatic model_clear();
      mq.delete();
      m_do = 0; m_last = 0; m_flush = 0; m_over = 0; m_under = 0;
      m_idx = '0; m_hist = '0; m_misp = '0;
   endtask

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s/%s: observed %0h expected %0h", cur_tag, name, obs, exp);
      end
   endtask

   task automatic check_all();
      check("count", 32'(count), 32'(mq.size()));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("do_update", 32'(do_update), 32'(m_do));
      check("last_taken", 32'(last_taken), 32'(m_last));
      check("upd_index", 32'(upd_index), 32'(m_idx));
      check("upd_hist", 32'(upd_hist), 32'(m_hist));
      check("flush", 32'(flush), 32'(m_flush));
      check("mispredicts", 32'(mispredicts), 32'(m_misp));
      check("overflow", 32'(overflow), 32'(m_over));
      check("underflow", 32'(underflow), 32'(m_under));
   endtask

   // One clock cycle: drive inputs, advance the model, compare after the edge.
   task automatic step(input logic e, input logic p, input logic [IWIDTH-1:0] pi,
                       input logic [HWIDTH-1:0] ph, input logic pt,
                       input logic r, input logic rt);
      ent_t h;
      logic had;
      logic mis;
      en = e; push = p; push_index = pi; push_hist = ph; push_taken = pt;
      resolve = r; resolve_taken = rt;
      if (e) begin
         had = (mq.size() > 0);
         mis = 1'b0;
         m_do = r && had;
         if (r && !had) m_under = 1'b1;
         if (m_do) begin
            h = mq.pop_front();
            m_last = rt; m_idx = h.idx; m_hist = h.hist;
            mis = (rt != h.tk);
         end
         if (p) begin
            if (mq.size() < DEPTH) mq.push_back('{idx: pi, hist: ph, tk: pt});
            else m_over = 1'b1;
         end
         if (mis) begin
            mq.delete();
            if (m_misp != 16'hFFFF) m_misp = m_misp + 16'd1;
         end
         m_flush = mis;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   // Reset asserted between edges; outputs must clear before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      en = 1'b0; push = 1'b0; resolve = 1'b0;
      #1 model_clear();
      check_all();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic head_tk();
      return (mq.size() > 0) ? mq[0].tk : 1'b0;
   endfunction

   initial begin
      logic e, p, r, rt;
      model_clear();
      #12;
      check_all();
      @(negedge clk);
      reset = 1'b0;

      cur_tag = "in_order";
      step(1, 1, 6'd5, 6'h11, 1, 0, 0);
      step(1, 1, 6'd9, 6'h22, 0, 0, 0);
      step(1, 1, 6'd2, 6'h33, 1, 0, 0);
      step(1, 0, 0, 0, 0, 1, 1);
      check("first_idx", 32'(upd_index), 32'd5);
      step(1, 0, 0, 0, 0, 1, 0);
      check("second_idx", 32'(upd_index), 32'd9);
      step(1, 0, 0, 0, 0, 1, 1);
      check("third_idx", 32'(upd_index), 32'd2);
      step(1, 0, 0, 0, 0, 0, 0);

      cur_tag = "overflow";
      for (int i = 0; i < DEPTH; i++) step(1, 1, 6'(i + 10), 6'(i), 1'(i), 0, 0);
      step(1, 1, 6'd63, 6'd63, 1, 0, 0);
      check("ovf_flag", 32'(overflow), 32'd1);
      step(1, 1, 6'd40, 6'd40, 0, 1, head_tk());
      check("full_swap_count", 32'(count), 32'(DEPTH));

      cur_tag = "mispredict";
      do_reset();
      step(1, 1, 6'd1, 6'd7, 1, 0, 0);
      step(1, 1, 6'd2, 6'd8, 0, 0, 0);
      step(1, 1, 6'd3, 6'd9, 1, 0, 0);
      step(1, 1, 6'd4, 6'd10, 1, 1, 0);
      check("mis_count", 32'(count), 32'd0);
      check("mis_counter", 32'(mispredicts), 32'd1);
      step(1, 0, 0, 0, 0, 0, 0);

      cur_tag = "underflow";
      do_reset();
      step(1, 0, 0, 0, 0, 1, 1);
      check("und_flag", 32'(underflow), 32'd1);
      step(1, 1, 6'd12, 6'd3, 1, 1, 0);

      cur_tag = "stall";
      do_reset();
      step(1, 1, 6'd21, 6'd1, 0, 0, 0);
      step(1, 1, 6'd22, 6'd2, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1'(i), 6'(i), 6'(i), 1'(i), 1'(~i), 1'(i));
      check("stall_count", 32'(count), 32'd2);
      step(1, 0, 0, 0, 0, 1, 0);
      check("stall_first", 32'(upd_index), 32'd21);

      cur_tag = "reset_mid";
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 1, 6'(i + 30), 6'(i), 1, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 1);
      step(1, 1, 6'd50, 6'd5, 0, 0, 0);
      step(1, 1, 6'd51, 6'd6, 1, 1, 0);
      step(1, 1, 6'd52, 6'd7, 1, 0, 0);
      en = 1'b1; resolve = 1'b1; resolve_taken = head_tk();
      do_reset();
      step(1, 0, 0, 0, 0, 0, 0);
      check("post_reset_upd", 32'(do_update), 32'd0);

      cur_tag = "random";
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(149) == 0) do_reset();
         e  = ($urandom_range(9) != 0);
         p  = ($urandom_range(1) == 1);
         r  = ($urandom_range(4) < 2);
         rt = ($urandom_range(4) != 0) ? head_tk() : 1'($urandom_range(1));
         step(e, p, 6'($urandom), 6'($urandom), 1'($urandom_range(1)), r, rt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_update_queue.md
BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 Parameter IWIDTH, default 6, table index width shared with the history tracker.
REQ-002 Parameter HWIDTH, default 6, history width shared with the history tracker.
REQ-003 Parameter DEPTH, default 4, number of in-flight predicted branches; power of two, >= 2.
REQ-004 Port clk  in  1  clock; all state updates on the rising edge.
REQ-005 Port reset  in  1  reset, asynchronous, active-high.
REQ-006 Port en  in  1  stall-release; when 0 all state and registered outputs hold.
REQ-007 Port push  in  1  fetch-stage request to enqueue one predicted branch.
REQ-008 Port push_index  in  IWIDTH  hashed branch index of the pushed branch.
REQ-009 Port push_hist  in  HWIDTH  history value read at prediction time.
REQ-010 Port push_taken  in  1  predicted direction.
REQ-011 Port resolve  in  1  execute-stage resolution of the oldest queued branch.
REQ-012 Port resolve_taken  in  1  actual direction of the resolved branch.
REQ-013 Port full  out  1  queue holds DEPTH entries.
REQ-014 Port empty  out  1  queue holds 0 entries.
REQ-015 Port count  out  $clog2(DEPTH)+1  current occupancy.
REQ-016 Port do_update  out  1  registered; pulse telling history/pattern tables to train.
REQ-017 Port last_taken  out  1  registered; actual direction for the training pulse.
REQ-018 Port upd_index  out  IWIDTH  registered; index of the trained entry.
REQ-019 Port upd_hist  out  HWIDTH  registered; history captured at prediction.
REQ-020 Port flush  out  1  registered; one-cycle pulse on misprediction.
REQ-021 Port mispredicts  out  16  saturating misprediction counter.
REQ-022 Port overflow  out  1  sticky; push dropped while full.
REQ-023 Port underflow  out  1  sticky; resolve received while empty.

Function
REQ-024 The queue SHALL be an in-order circular FIFO of {index, hist, taken}, with head/tail pointers wrapping modulo DEPTH.
REQ-025 full, empty and count SHALL be combinational from current occupancy.
REQ-026 With en=1, push and !full SHALL write the tail entry and increment occupancy.
REQ-027 With en=1, push while full and resolve=1 SHALL perform pop and push in the same cycle, occupancy unchanged.
REQ-028 With en=1, push while full without resolve SHALL drop the push and set overflow.
REQ-029 With en=1, resolve and !empty SHALL pop the head; the next cycle do_update=1, last_taken=resolve_taken, upd_index/upd_hist = head fields.
REQ-030 do_update SHALL be 1 for exactly one cycle per accepted resolve and 0 in every other enabled cycle.
REQ-031 Resolve while empty SHALL be ignored (do_update=0 next cycle) and SHALL set underflow.
REQ-032 A simultaneous push and resolve on an empty queue SHALL enqueue only; resolve counts as underflow.
REQ-033 If resolve_taken != head.taken, the next cycle flush=1 and all entries SHALL be discarded (occupancy 0, head=tail), including any same-cycle push.
REQ-034 On misprediction, mispredicts SHALL increment by 1, saturating at 16'hFFFF.
REQ-035 Correct predictions SHALL leave flush=0 and mispredicts unchanged.
REQ-036 With en=0, pushes and resolves SHALL be ignored, no flags set, all outputs hold.

Reset
REQ-037 Reset SHALL asynchronously clear head, tail, occupancy, do_update, last_taken, upd_index, upd_hist, flush, mispredicts, overflow, underflow to 0; empty=1, full=0.
REQ-038 Reset asserted mid-operation SHALL discard all queued entries; no do_update pulse SHALL follow deassertion.
REQ-039 Queue storage contents need not be reset.

Verification
REQ-040 Push 3 (idx 5/9/2, taken 1/0/1), resolve 3 matching -> do_update pulses with upd_index 5,9,2 in order, flush=0, mispredicts=0, empty=1.
REQ-041 Push DEPTH entries, then push without resolve -> full=1, entry dropped, overflow=1; then resolve+push same cycle -> count stays DEPTH.
REQ-042 Push 3, resolve head with resolve_taken opposite and simultaneous push -> next cycle flush=1, do_update=1, count=0, mispredicts=1.
REQ-043 Resolve on empty queue -> do_update stays 0, underflow=1, count=0.
REQ-044 Push 2, hold en=0 while toggling push/resolve for 4 cycles -> count=2, no pulses; en=1 resolve -> first entry trained.
REQ-045 Push 2 wrapping pointers past DEPTH-1, assert reset mid-stream -> all outputs 0, empty=1, no do_update after release.
